// File: rtl/map_loader_pkg.sv
// Shared map geometry, default base address and loader state encoding.
// Imported by map_row_packer and map_loader.
package map_loader_pkg;

   localparam int MAP_WIDTH  = 7;
   localparam int H_ROWS_DEF = 8;
   localparam int V_ROWS_DEF = 7;
   localparam logic [9:0] MAP_BASE = 10'h000;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_H,
      S_LOAD_V,
      S_VERIFY,
      S_DONE
   } state_t;

endpackage

// File: rtl/map_loader_row_packer.sv
// Combinational row packer: bit-reverses a ROM row into a memory word.
// Ports: sel_v (1 = vertical row), hrow, vrow in; word out.
import map_loader_pkg::*;

module map_row_packer (
   input  logic                 sel_v,
   input  logic [MAP_WIDTH-1:0] hrow,
   input  logic [MAP_WIDTH:0]   vrow,
   output logic [7:0]           word
);

   // Column 0 of a row lands on the most significant used bit.
   always_comb begin
      word = '0;
      if (sel_v) begin
         for (int i = 0; i <= MAP_WIDTH; i++)
            word[MAP_WIDTH-i] = vrow[i];
      end else begin
         for (int i = 0; i < MAP_WIDTH; i++)
            word[MAP_WIDTH-1-i] = hrow[i];
      end
   end

endmodule

// File: rtl/map_loader.sv
// Map memory loader: copies wall ROMs into map memory on a start pulse.
// Ports: clk, rst, start; hmap/vmap ROM addr/data; mem_addr/din/we/dout;
// busy, done, err. Macro MAP_LOADER_VERIFY_EN adds a read-back pass.
import map_loader_pkg::*;

module map_loader #(
   parameter logic [9:0] BASE_ADDR = MAP_BASE,
   parameter int         H_ROWS    = H_ROWS_DEF,
   parameter int         V_ROWS    = V_ROWS_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic [3:0]           hmap_addr,
   input  logic [MAP_WIDTH-1:0] hmap_data,
   output logic [3:0]           vmap_addr,
   input  logic [MAP_WIDTH:0]   vmap_data,
   output logic [9:0]           mem_addr,
   output logic [7:0]           mem_din,
   output logic                 mem_we,
   input  logic [7:0]           mem_dout,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   localparam logic [3:0] H_LAST = 4'(H_ROWS - 1);
   localparam logic [3:0] V_LAST = 4'(V_ROWS - 1);
   localparam logic [3:0] H_CNT  = 4'(H_ROWS);
   localparam logic [3:0] N_ROWS = 4'(H_ROWS + V_ROWS);
   localparam logic [9:0] V_OFF  = 10'(H_ROWS);

   state_t     state, state_n;
   logic [3:0] r, r_n;
   logic [3:0] h_hold, v_hold;
   logic       h_sel, v_sel, sel_v;
   logic [3:0] v_idx;
   logic [7:0] word;

   map_row_packer u_pack (
      .sel_v (sel_v),
      .hrow  (hmap_data),
      .vrow  (vmap_data),
      .word  (word)
   );

   // ROM addresses follow the counter while a row is selected, else hold.
   assign hmap_addr = h_sel ? r : h_hold;
   assign vmap_addr = v_sel ? v_idx : v_hold;
   assign mem_din   = mem_we ? word : 8'h00;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         r      <= '0;
         h_hold <= '0;
         v_hold <= '0;
      end else begin
         state <= state_n;
         r     <= r_n;
         if (h_sel) h_hold <= r;
         if (v_sel) v_hold <= v_idx;
      end
   end

   always_comb begin
      state_n  = state;
      r_n      = r;
      busy     = 1'b0;
      done     = 1'b0;
      mem_we   = 1'b0;
      mem_addr = BASE_ADDR;
      h_sel    = 1'b0;
      v_sel    = 1'b0;
      sel_v    = 1'b0;
      v_idx    = r;
      unique case (state)
         S_IDLE: begin
            if (start) begin
               state_n = S_LOAD_H;
               r_n     = '0;
            end
         end
         S_LOAD_H: begin
            busy     = 1'b1;
            mem_we   = 1'b1;
            h_sel    = 1'b1;
            mem_addr = BASE_ADDR + {6'd0, r};
            if (r == H_LAST) begin
               state_n = S_LOAD_V;
               r_n     = '0;
            end else begin
               r_n = r + 4'd1;
            end
         end
         S_LOAD_V: begin
            busy     = 1'b1;
            mem_we   = 1'b1;
            v_sel    = 1'b1;
            sel_v    = 1'b1;
            mem_addr = BASE_ADDR + V_OFF + {6'd0, r};
            if (r == V_LAST) begin
`ifdef MAP_LOADER_VERIFY_EN
               state_n = S_VERIFY;
`else
               state_n = S_DONE;
`endif
               r_n = '0;
            end else begin
               r_n = r + 4'd1;
            end
         end
         S_VERIFY: begin
            // r walks the flat image 0..N_ROWS-1, then one drain cycle.
            busy     = 1'b1;
            mem_addr = BASE_ADDR + {6'd0, r};
            if (r < H_CNT) begin
               h_sel = 1'b1;
            end else if (r < N_ROWS) begin
               v_sel = 1'b1;
               sel_v = 1'b1;
               v_idx = r - H_CNT;
            end
            if (r == N_ROWS) begin
               state_n = S_DONE;
            end else begin
               r_n = r + 4'd1;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

`ifdef MAP_LOADER_VERIFY_EN
   logic [7:0] exp_q;
   logic       exp_v;
   logic       err_q;

   // Memory read data lags the address by one cycle, so the expected
   // word is delayed to line up with mem_dout.
   always_ff @(posedge clk) begin
      if (rst) begin
         exp_q <= '0;
         exp_v <= 1'b0;
         err_q <= 1'b0;
      end else begin
         exp_q <= word;
         exp_v <= (state == S_VERIFY) && (r != N_ROWS);
         if (state == S_IDLE && start)
            err_q <= 1'b0;
         else if (exp_v && mem_dout != exp_q)
            err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   logic unused_dout;
   assign unused_dout = ^mem_dout;
   assign err = 1'b0;
`endif

endmodule
